// File: rtl/booth_mul_seq_if.sv
// Bundle between the ALU sequencer/recoder and the sequential Booth multiplier.
// start is a request taken only while busy=0; done pulses for one cycle when product is valid.
interface booth_mul_seq_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [1:0]           m;
    logic [1:0]           y;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic                 err;
    logic [1:0]           dbg_state;

    modport slave (
        input  start, mcand, mplier, y,
        output m, busy, done, product, err, dbg_state
    );

    modport master (
        output start, mcand, mplier, y,
        input  m, busy, done, product, err, dbg_state
    );
endinterface

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: one recoded digit per cycle from an external
// combinational recoder, signed 2*WIDTH-bit product after WIDTH iterations.
module booth_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    booth_mul_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [WIDTH:0]       m_q, m_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 err_q, err_d;

    logic [WIDTH:0]       a_step;
    logic [2*WIDTH+1:0]   shifted;

    // y is consumed in the same cycle m is driven; the recoder adds no register stage.
    always_comb begin
        unique case (bus.y)
            2'b01:   a_step = a_q + m_q;
            2'b10:   a_step = a_q - m_q;
            default: a_step = a_q;
        endcase
        shifted = {a_step[WIDTH], a_step, q_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = '0;
                    q_d     = bus.mplier;
                    qm1_d   = 1'b0;
                    m_d     = {bus.mcand[WIDTH-1], bus.mcand};
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // shifted holds {A', Q} with A' sign-replicated; its LSB becomes the new q_m1.
                a_d   = shifted[2*WIDTH+1:WIDTH+1];
                q_d   = shifted[WIDTH:1];
                qm1_d = shifted[0];
                cnt_d = cnt_q + CW'(1);
                if (bus.y == 2'b11) err_d = 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    product_d = {shifted[2*WIDTH:WIDTH+1], shifted[WIDTH:1]};
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.m         = (state_q == RUN) ? {q_q[0], qm1_q} : 2'b00;
        bus.busy      = (state_q == RUN) || (state_q == DONE);
        bus.done      = (state_q == DONE);
        bus.product   = product_q;
        bus.err       = err_q;
        bus.dbg_state = state_q;
    end
endmodule

// File: tb/tb_booth_mul_seq.sv
// Bench for booth_mul_seq: directed and random multiplies with a scoreboard fed at
// issue time and drained by a done-triggered monitor.
module tb_booth_mul_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic force_y = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [2*W:0] exp_q[$];

  booth_mul_seq_if #(.WIDTH(W)) bif ();

  booth_mul_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif.slave)
  );

  always #5 clk = ~clk;

  // Radix-2 recoder: window 01 adds, 10 subtracts, otherwise shift only.
  assign bif.y = force_y ? 2'b11 :
                 (bif.m == 2'b01) ? 2'b01 :
                 (bif.m == 2'b10) ? 2'b10 : 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Product as sum of Booth digits (q[i-1]-q[i]) * mcand * 2^i, with one digit optionally dropped.
  function automatic logic [2*W-1:0] ref_prod(input logic signed [W-1:0] a,
                                              input logic signed [W-1:0] b, input int skip);
    longint p;
    longint d;
    logic   prev;
    p = longint'(a) * longint'(b);
    if (skip >= 0) begin
      prev = (skip > 0) ? b[skip-1] : 1'b0;
      d = longint'(prev) - longint'(b[skip]);
      p = p - d * longint'(a) * (longint'(1) << skip);
    end
    return p[2*W-1:0];
  endfunction

  always @(negedge clk) begin
    if (bif.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(bif.done), 32'd0);
      end else begin
        logic [2*W:0] e;
        e = exp_q.pop_front();
        check("product", 32'(bif.product), 32'(e[2*W-1:0]));
        check("err_at_done", 32'(bif.err), 32'(e[2*W]));
      end
    end
  end

  task automatic wait_idle();
    @(negedge clk);
    for (int k = 0; k < 30 && bif.busy; k++) @(negedge clk);
  endtask

  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int skip,
                         input bit zero_y, input int pulse_at);
    int lat;
    exp_q.push_back({(skip >= 0), ref_prod(a, b, skip)});
    wait_idle();
    bif.start = 1'b1;
    bif.mcand = a;
    bif.mplier = b;
    @(posedge clk); #1;
    bif.start = 1'b0;
    lat = -1;
    for (int n = 0; n <= 20 && lat < 0; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      if (bif.done) begin
        lat = n;
      end else begin
        if (n == 0) check("err_clear_on_start", 32'(bif.err), 32'd0);
        if (zero_y) check("y_zero", 32'(bif.y), 32'd0);
        if (n == skip) begin
          check("err_before_force", 32'(bif.err), 32'd0);
          force_y = 1'b1;
        end
        if (skip >= 0 && n == skip + 1) begin
          force_y = 1'b0;
          check("err_rise", 32'(bif.err), 32'd1);
        end
        if (n == pulse_at) begin
          bif.start = 1'b1;
          bif.mcand = ~a;
          bif.mplier = a;
        end
        if (pulse_at >= 0 && n == pulse_at + 1) bif.start = 1'b0;
      end
    end
    force_y = 1'b0;
    bif.start = 1'b0;
    check("latency", 32'(lat), 32'(W));
    if (skip >= 0) begin
      @(posedge clk); #1;
      check("err_hold_idle", 32'(bif.err), 32'd1);
    end
  endtask

  initial begin
    int n1;
    int n2;
    bif.start = 1'b0;
    bif.mcand = '0;
    bif.mplier = '0;
    #12;
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_done", 32'(bif.done), 32'd0);
    check("rst_err", 32'(bif.err), 32'd0);
    check("rst_product", 32'(bif.product), 32'd0);
    check("rst_m", 32'(bif.m), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_mul(8'd3, 8'd5, -1, 1'b0, -1);
    run_mul(8'h80, 8'h80, -1, 1'b0, -1);
    run_mul(8'h7F, 8'h80, -1, 1'b0, -1);
    run_mul(8'h5A, 8'h00, -1, 1'b1, -1);
    run_mul(8'd3, 8'd5, 2, 1'b0, -1);
    run_mul(8'h25, 8'hE3, -1, 1'b0, -1);
    run_mul(8'h11, 8'h9C, -1, 1'b0, 3);

    // Back-to-back with start held high.
    exp_q.push_back({1'b0, ref_prod(8'hC3, 8'h27, -1)});
    exp_q.push_back({1'b0, ref_prod(8'hC3, 8'h27, -1)});
    wait_idle();
    bif.start = 1'b1;
    bif.mcand = 8'hC3;
    bif.mplier = 8'h27;
    @(posedge clk); #1;
    n1 = -1;
    n2 = -1;
    for (int n = 0; n < 40 && n2 < 0; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      if (bif.done) begin
        if (n1 < 0) n1 = n;
        else n2 = n;
      end
    end
    bif.start = 1'b0;
    check("b2b_first_latency", 32'(n1), 32'(W));
    check("b2b_spacing", 32'(n2 - n1), 32'(W + 2));

    // Asynchronous reset mid-RUN discards the operation.
    wait_idle();
    bif.start = 1'b1;
    bif.mcand = 8'h33;
    bif.mplier = 8'h44;
    @(posedge clk); #1;
    bif.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(bif.busy), 32'd0);
    check("arst_done", 32'(bif.done), 32'd0);
    check("arst_err", 32'(bif.err), 32'd0);
    check("arst_product", 32'(bif.product), 32'd0);
    check("arst_m", 32'(bif.m), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_mul(8'hF6, 8'h0D, -1, 1'b0, -1);

    for (int i = 0; i < 20; i++) begin
      run_mul(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), -1, 1'b0, -1);
    end

    repeat (4) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
